branch_resolve_update: RTL
==========================

Name: branch_resolve_update

Overview:
- Execute-stage producer for the branch-predictor update interface (IUpdatePredictionIO: valid, pc, is_br, taken, target). It is the write side that feeds the predictor's update port.
- Compares the fetch-time predicted next PC, carried down the pipeline, against the resolved next PC.
- Emits a registered predictor update and a redirect pulse on mispredict.
- After a redirect, discards wrong-path instructions until the instruction at the redirect target arrives.

Parameters:
- UPDATE_ALL, 0, 1 = send an update for every accepted instruction; 0 = send only for branches and for non-branch aliases that predicted wrongly.
- CNT_WIDTH, 32, width of the statistics counters (used only with BRANCH_STATS_EN).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ex_valid  in  1  a resolved instruction is presented this cycle (no backpressure; always consumed)
- ex_pc  in  32  PC of the instruction
- ex_pred_next  in  32  next PC that fetch predicted for this instruction
- ex_is_br  in  1  instruction is a branch or jump
- ex_taken  in  1  branch resolved taken (ignored if !ex_is_br)
- ex_target  in  32  resolved taken target
- ext_flush  in  1  trap/exception flush; overrides everything
- upd_valid  out  1  drives updateio.valid
- upd_pc  out  32  drives updateio.pc
- upd_is_br  out  1  drives updateio.is_br
- upd_taken  out  1  drives updateio.taken
- upd_target  out  32  drives updateio.target
- redirect_valid  out  1  one-cycle fetch redirect pulse
- redirect_pc  out  32  correct next PC

Behaviour:
- Clocking and reset:
  - Single clock, clk.
  - reset is asynchronous and active-high.
  - On reset: all outputs 0, state=RUN, drain_pc=0.
- Next-PC calculation:
  - actual_next = (ex_is_br && ex_taken) ? ex_target : ex_pc+4.
  - The add is 32-bit and wraps: 0xFFFFFFFC+4 = 0x00000000.
  - mispredict = (ex_pred_next != actual_next).
- States:
  - RUN: every ex_valid input is processed.
  - DRAIN: an input with ex_pc == drain_pc is processed and the state moves to RUN. Any other input is squashed: no update, no redirect.
- Processing an input accepted in cycle N (all outputs registered, 1-cycle latency):
  - In cycle N+1, upd_valid=1 if ex_is_br, or mispredict, or UPDATE_ALL.
  - upd_pc=ex_pc, upd_is_br=ex_is_br, upd_taken=ex_is_br&ex_taken, upd_target=ex_target.
  - A non-branch with a mispredict therefore sends is_br=0, which clears the aliased predictor entry.
- Mispredict on a processed input:
  - In cycle N+1, redirect_valid=1 and redirect_pc=actual_next.
  - drain_pc=actual_next and the state becomes DRAIN from cycle N+1.
  - This holds even when the input is the one that just exited DRAIN: DRAIN is re-entered with the new target.
- Output defaults: upd_valid and redirect_valid are 0 in any cycle with no processed input. Data outputs hold their last values.
- ext_flush=1 in cycle N:
  - The input in cycle N is dropped.
  - Outputs valid=0 in N+1.
  - State is forced to RUN.
  - A redirect already being driven in N (from N-1) is not retracted.
- ex_valid=0 in DRAIN: the block stays in DRAIN indefinitely. There is no timeout.
- Reset mid-DRAIN returns to RUN immediately with all outputs 0.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- When defined, three saturating counters (CNT_WIDTH bits, reset 0) are added as outputs:
  - stat_branches: +1 per processed input with ex_is_br.
  - stat_mispred: +1 per processed mispredict.
  - stat_squashed: +1 per input discarded in DRAIN.
  - Counters hold at all-ones; ext_flush does not clear them.
- When not defined, these ports and registers do not exist.
- Functional behaviour is identical with and without the macro.

Test Plan:
- Correct taken branch: pc=0x100, pred_next=0x200, taken, target=0x200. Next cycle: upd_valid=1, pc=0x100, is_br=1, taken=1, target=0x200. redirect_valid=0.
- Mispredicted not-taken: pc=0x100, pred_next=0x200, not taken. Next cycle: redirect_valid=1, redirect_pc=0x104, update taken=0. Then inputs pc=0x200 and 0x204 are squashed (no upd_valid). Input pc=0x104 is processed and the state returns to RUN.
- Non-branch alias: pc=0x40, is_br=0, pred_next=0x80 gives upd_valid=1, is_br=0, redirect_pc=0x44. pc=0x44 with pred_next=0x48 gives no update when UPDATE_ALL=0, and upd_valid=1 when UPDATE_ALL=1.
- Wrap: pc=0xFFFFFFFC, not-taken branch, pred_next=0x0 gives no redirect and an update with taken=0.
- ext_flush during DRAIN: drain_pc=0x104, then flush asserted together with ex_valid pc=0x104. Next cycle: no outputs valid, state RUN, and the following input pc=0x300 is processed.
- Async reset asserted mid-DRAIN, between clock edges: outputs go to 0 immediately. After release, input pc=0x500 with a correct prediction is processed normally.

Source files
------------

// File: rtl/branch_resolve_update.sv
// Execute-stage branch resolution: compares the fetch-time predicted next PC against the
// resolved one, drives the predictor update port and a one-cycle fetch redirect, and squashes
// wrong-path instructions until the redirect target arrives. Optional statistics counters are
// built only when BRANCH_STATS_EN is defined.
module branch_resolve_update #(
   parameter bit UPDATE_ALL = 1'b0,
   parameter int CNT_WIDTH  = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ex_valid,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_pred_next,
   input  logic        ex_is_br,
   input  logic        ex_taken,
   input  logic [31:0] ex_target,
   input  logic        ext_flush,
   output logic        upd_valid,
   output logic [31:0] upd_pc,
   output logic        upd_is_br,
   output logic        upd_taken,
   output logic [31:0] upd_target,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc
`ifdef BRANCH_STATS_EN
   ,
   output logic [CNT_WIDTH-1:0] stat_branches,
   output logic [CNT_WIDTH-1:0] stat_mispred,
   output logic [CNT_WIDTH-1:0] stat_squashed
`endif
);

   // state | meaning
   // RUN   | every valid input is resolved; may update the predictor and redirect fetch
   // DRAIN | wrong-path inputs are squashed until ex_pc == drain_pc, which is then resolved

   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_DRAIN = 1'b1;

   if (CNT_WIDTH < 1) begin : g_bad_cnt_width
      $error("CNT_WIDTH must be at least 1");
   end

   logic [0:0]  state;
   logic [0:0]  state_nxt;
   logic [31:0] drain_pc;
   logic [31:0] drain_pc_nxt;

   logic [31:0] seq_next;
   logic [31:0] actual_next;
   logic        mispredict;
   logic        accept;
   logic        process;
   logic        squash;
   logic        send_upd;

   always_comb begin
      seq_next    = ex_pc + 32'd4;
      actual_next = (ex_is_br && ex_taken) ? ex_target : seq_next;
      mispredict  = (ex_pred_next != actual_next);
      accept      = ex_valid && !ext_flush;
      process     = accept && ((state == ST_RUN) || (ex_pc == drain_pc));
      squash      = accept && !process;
      send_upd    = process && (ex_is_br || mispredict || UPDATE_ALL);
   end

   // A mispredict on the very instruction that ends DRAIN re-arms DRAIN with its own target.
   always_comb begin
      state_nxt    = state;
      drain_pc_nxt = drain_pc;
      if (ext_flush) begin
         state_nxt = ST_RUN;
      end else if (process) begin
         if (mispredict) begin
            state_nxt    = ST_DRAIN;
            drain_pc_nxt = actual_next;
         end else begin
            state_nxt = ST_RUN;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_RUN;
         drain_pc <= 32'd0;
      end else begin
         state    <= state_nxt;
         drain_pc <= drain_pc_nxt;
      end
   end

   // Data fields only move when something is actually sent; otherwise they hold.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         upd_valid  <= 1'b0;
         upd_pc     <= 32'd0;
         upd_is_br  <= 1'b0;
         upd_taken  <= 1'b0;
         upd_target <= 32'd0;
      end else begin
         upd_valid <= send_upd;
         if (send_upd) begin
            upd_pc     <= ex_pc;
            upd_is_br  <= ex_is_br;
            upd_taken  <= ex_is_br && ex_taken;
            upd_target <= ex_target;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         redirect_valid <= 1'b0;
         redirect_pc    <= 32'd0;
      end else begin
         redirect_valid <= process && mispredict;
         if (process && mispredict) begin
            redirect_pc <= actual_next;
         end
      end
   end

`ifdef BRANCH_STATS_EN
   localparam logic [CNT_WIDTH-1:0] STAT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] STAT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_branches <= '0;
         stat_mispred  <= '0;
         stat_squashed <= '0;
      end else begin
         if (process && ex_is_br && (stat_branches != STAT_MAX)) begin
            stat_branches <= stat_branches + STAT_ONE;
         end
         if (process && mispredict && (stat_mispred != STAT_MAX)) begin
            stat_mispred <= stat_mispred + STAT_ONE;
         end
         if (squash && (stat_squashed != STAT_MAX)) begin
            stat_squashed <= stat_squashed + STAT_ONE;
         end
      end
   end
`else
   logic unused_squash;
   assign unused_squash = squash;
`endif

endmodule
